rc4_keystream_gen: RTL and testbench

//  RC4 keystream source that feeds the byte-wide XOR decryption stage.
//  On start: latches a multi-byte key, runs the full key-scheduling algorithm
//  (KSA) as a multi-cycle FSM over an internal 256x8 S-box, then runs the

---
 rtl/rc4_keystream_gen_if.sv | 44 ++++
 rtl/rc4_keystream_gen.sv | 234 +++++++++++++++++++++++
 tb/tb_rc4_keystream_gen.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/rc4_keystream_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : rc4_keystream_gen_if
//  Description : Control and keystream stream bundle for rc4_keystream_gen.
//                master : caller side (drives start/key/ks_ready)
//                slave  : generator side (drives busy/ks_valid/ks_byte)
//                Signals:
//                  start    1-cycle pulse: latch key, re-initialise, run
//                  key      8*KEY_BYTES, byte k = key[8k+7:8k], byte 0 first
//                  busy     high while the S-box is being built (FILL/KSA)
//                  ks_valid ks_byte holds a valid keystream byte
//                  ks_ready downstream accepts when ks_valid && ks_ready
//                  ks_byte  keystream byte
//  Revision    : 1.0 - initial release
// ============================================================================
interface rc4_keystream_gen_if #(
    parameter int KEY_BYTES = 16
);
    logic                   start;
    logic [8*KEY_BYTES-1:0] key;
    logic                   busy;
    logic                   ks_valid;
    logic                   ks_ready;
    logic [7:0]             ks_byte;

    modport master (
        output start,
        output key,
        output ks_ready,
        input  busy,
        input  ks_valid,
        input  ks_byte
    );

    modport slave (
        input  start,
        input  key,
        input  ks_ready,
        output busy,
        output ks_valid,
        output ks_byte
    );
endinterface
`default_nettype wire

// File: rtl/rc4_keystream_gen.sv
`default_nettype none
// ============================================================================
//  Module      : rc4_keystream_gen
//  Description : RC4 keystream source. On start the key is latched, the
//                256-entry S-box is filled with the identity permutation,
//                scrambled by the key-scheduling pass (one swap per cycle),
//                and then the PRGA emits one keystream byte per cycle on a
//                valid/ready stream.
//                Ports:
//                  clk    rising-edge clock
//                  reset  asynchronous, active-low; clears all control state
//                  bus    rc4_keystream_gen_if.slave (start, key, busy,
//                         ks_valid, ks_ready, ks_byte)
//  Revision    : 1.0 - initial release
// ============================================================================
module rc4_keystream_gen #(
    parameter int KEY_BYTES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    rc4_keystream_gen_if.slave    bus
);

    localparam int c_KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [c_KIDX_W-1:0] c_KIDX_LAST = c_KIDX_W'(KEY_BYTES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_KSA  = 2'd2;
    localparam logic [1:0] S_GEN  = 2'd3;

    logic [1:0]             r_state;
    logic [1:0]             w_next_state;
    logic                   w_busy;

    logic [8*KEY_BYTES-1:0] r_key;
    logic [7:0]             r_cnt;
    logic [7:0]             r_i;
    logic [7:0]             r_j;
    logic [c_KIDX_W-1:0]    r_kidx;
    logic                   r_ks_valid;
    logic [7:0]             r_ks_byte;

    // S-box is not reset: FILL rebuilds it before it is ever read.
    logic [7:0]             r_sbox [256];

    logic [7:0]             w_key_bytes [KEY_BYTES];
    logic [7:0]             w_key_byte;

    logic [7:0]             w_ksa_si;
    logic [7:0]             w_ksa_j;
    logic [7:0]             w_ksa_sj;

    logic                   w_step;
    logic [7:0]             w_gen_i;
    logic [7:0]             w_gen_si;
    logic [7:0]             w_gen_j;
    logic [7:0]             w_gen_sj;
    logic [7:0]             w_gen_t;
    logic [7:0]             w_gen_ks;

    logic                   w_wr0_en;
    logic [7:0]             w_wr0_addr;
    logic [7:0]             w_wr0_data;
    logic                   w_wr1_en;
    logic [7:0]             w_wr1_addr;
    logic [7:0]             w_wr1_data;

    generate
        for (genvar k = 0; k < KEY_BYTES; k++) begin : g_key_bytes
            assign w_key_bytes[k] = r_key[8*k +: 8];
        end
    endgenerate

    assign w_key_byte = w_key_bytes[r_kidx];

    // Key scheduling: i is the fill/sweep counter itself.
    assign w_ksa_si = r_sbox[r_cnt];
    assign w_ksa_j  = r_j + w_ksa_si + w_key_byte;
    assign w_ksa_sj = r_sbox[w_ksa_j];

    // PRGA step. A start in GEN takes priority and suppresses the step.
    assign w_step   = (r_state == S_GEN) && !bus.start && (!r_ks_valid || bus.ks_ready);
    assign w_gen_i  = r_i + 8'd1;
    assign w_gen_si = r_sbox[w_gen_i];
    assign w_gen_j  = r_j + w_gen_si;
    assign w_gen_sj = r_sbox[w_gen_j];
    assign w_gen_t  = w_gen_si + w_gen_sj;

    // Output byte is read from the post-swap table; the two swapped slots
    // are forwarded because the array still holds pre-swap values this cycle.
    always_comb begin
        if (w_gen_t == w_gen_i) begin
            w_gen_ks = w_gen_sj;
        end else if (w_gen_t == w_gen_j) begin
            w_gen_ks = w_gen_si;
        end else begin
            w_gen_ks = r_sbox[w_gen_t];
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (bus.start)        w_next_state = S_FILL;
            S_FILL: if (r_cnt == 8'hFF)   w_next_state = S_KSA;
            S_KSA:  if (r_cnt == 8'hFF)   w_next_state = S_GEN;
            S_GEN:  if (bus.start)        w_next_state = S_FILL;
            default:                      w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (busy and S-box write ports; at most two writes/cycle)
    // ------------------------------------------------------------------
    always_comb begin
        w_busy     = 1'b0;
        w_wr0_en   = 1'b0;
        w_wr0_addr = r_cnt;
        w_wr0_data = r_cnt;
        w_wr1_en   = 1'b0;
        w_wr1_addr = w_ksa_j;
        w_wr1_data = w_ksa_si;
        case (r_state)
            S_FILL: begin
                w_busy   = 1'b1;
                w_wr0_en = 1'b1;
            end
            S_KSA: begin
                w_busy     = 1'b1;
                w_wr0_en   = 1'b1;
                w_wr0_data = w_ksa_sj;
                w_wr1_en   = 1'b1;
            end
            S_GEN: begin
                w_wr0_en   = w_step;
                w_wr0_addr = w_gen_i;
                w_wr0_data = w_gen_sj;
                w_wr1_en   = w_step;
                w_wr1_addr = w_gen_j;
                w_wr1_data = w_gen_si;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    // When both ports hit the same entry (i == j') they carry the same value.
    always_ff @(posedge clk) begin
        if (w_wr0_en) begin
            r_sbox[w_wr0_addr] <= w_wr0_data;
        end
        if (w_wr1_en) begin
            r_sbox[w_wr1_addr] <= w_wr1_data;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_key      <= '0;
            r_cnt      <= 8'd0;
            r_i        <= 8'd0;
            r_j        <= 8'd0;
            r_kidx     <= '0;
            r_ks_valid <= 1'b0;
            r_ks_byte  <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_key <= bus.key;
                        r_cnt <= 8'd0;
                    end
                end
                S_FILL: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (r_cnt == 8'hFF) begin
                        r_j    <= 8'd0;
                        r_kidx <= '0;
                    end
                end
                S_KSA: begin
                    r_cnt  <= r_cnt + 8'd1;
                    r_j    <= w_ksa_j;
                    // Key index is its own counter so any KEY_BYTES wraps correctly.
                    r_kidx <= (r_kidx == c_KIDX_LAST) ? '0 : r_kidx + 1'b1;
                    if (r_cnt == 8'hFF) begin
                        r_i <= 8'd0;
                        r_j <= 8'd0;
                    end
                end
                S_GEN: begin
                    if (bus.start) begin
                        r_key      <= bus.key;
                        r_cnt      <= 8'd0;
                        r_ks_valid <= 1'b0;
                    end else if (w_step) begin
                        r_i        <= w_gen_i;
                        r_j        <= w_gen_j;
                        r_ks_byte  <= w_gen_ks;
                        r_ks_valid <= 1'b1;
                    end
                end
                default: begin
                    r_cnt <= 8'd0;
                end
            endcase
        end
    end

    assign bus.busy     = w_busy;
    assign bus.ks_valid = r_ks_valid;
    assign bus.ks_byte  = r_ks_byte;

endmodule
`default_nettype wire

// File: tb/tb_rc4_keystream_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rc4_keystream_gen
//  Description : Self-checking bench for rc4_keystream_gen. The DUT is built
//                with a 12-byte key so 3-, 4- and 6-byte reference keys can be
//                applied by cyclic repetition. Expected bytes are queued when
//                a key is started and popped on each accepted transfer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rc4_keystream_gen;

    localparam int c_KB = 12;

    logic clk;
    logic reset;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q [$];

    rc4_keystream_gen_if #(.KEY_BYTES(c_KB)) bus ();

    rc4_keystream_gen #(.KEY_BYTES(c_KB)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8*c_KB-1:0] make_key(input string s);
        logic [8*c_KB-1:0] r;
        r = '0;
        for (int k = 0; k < c_KB; k++) begin
            r[8*k +: 8] = s[k % s.len()];
        end
        return r;
    endfunction

    task automatic push_lit(input logic [79:0] v, input int n);
        for (int m = 0; m < n; m++) begin
            exp_q.push_back(v[8*(n-1-m) +: 8]);
        end
    endtask

    // Reference RC4 over the true key length; pushes bytes skip..skip+n-1.
    task automatic model_push(input string s, input int skip, input int n);
        logic [7:0] sb [256];
        logic [7:0] t;
        logic [7:0] kb;
        int i;
        int j;
        for (int a = 0; a < 256; a++) sb[a] = 8'(a);
        j = 0;
        for (int a = 0; a < 256; a++) begin
            kb = s[a % s.len()];
            j = (j + int'(sb[a]) + int'(kb)) % 256;
            t = sb[a]; sb[a] = sb[j]; sb[j] = t;
        end
        i = 0;
        j = 0;
        for (int m = 0; m < skip + n; m++) begin
            i = (i + 1) % 256;
            j = (j + int'(sb[i])) % 256;
            t = sb[i]; sb[i] = sb[j]; sb[j] = t;
            if (m >= skip) exp_q.push_back(sb[(int'(sb[i]) + int'(sb[j])) % 256]);
        end
    endtask

    // Called at a negedge. mode 1 injects an ignored start (other key) mid-KSA.
    task automatic start_key(input string s, input int mode, input logic [79:0] lit, input int nlit);
        exp_q.delete();
        push_lit(lit, nlit);
        bus.key      = make_key(s);
        bus.start    = 1'b1;
        bus.ks_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("after_start_busy", bus.busy, 1);
        check("after_start_valid", bus.ks_valid, 0);
        for (int c = 1; c < 512; c++) begin
            if (mode == 1 && c == 300) begin
                bus.key   = make_key("Wiki");
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        check("busy_e511", bus.busy, 1);
        check("valid_e511", bus.ks_valid, 0);
        @(negedge clk);
        check("busy_e512", bus.busy, 0);
        check("valid_e512", bus.ks_valid, 0);
        @(negedge clk);
        check("valid_e513", bus.ks_valid, 1);
    endtask

    // Called at a negedge. Accepts n bytes, optionally with random ready.
    task automatic consume(input int n, input bit rnd);
        int         got;
        int         budget;
        bit         stalled;
        bit         rdy;
        logic [7:0] held;
        logic [7:0] e;
        got     = 0;
        budget  = 20 * n + 100;
        stalled = 1'b0;
        held    = 8'd0;
        while (got < n && budget > 0) begin
            rdy = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (stalled) begin
                check("stall_valid", bus.ks_valid, 1);
                check("stall_hold", bus.ks_byte, held);
            end
            bus.ks_ready = rdy;
            stalled = 1'b0;
            if (bus.ks_valid) begin
                if (rdy) begin
                    check("sb_nonempty", exp_q.size() != 0, 1);
                    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
                    check("ks_byte", bus.ks_byte, e);
                    got++;
                end else begin
                    stalled = 1'b1;
                    held    = bus.ks_byte;
                end
            end
            budget--;
            @(negedge clk);
        end
        if (got < n) check("consume_timeout", got, n);
    endtask

    // Called at a negedge: asynchronous reset mid-low-phase, released next negedge.
    task automatic reset_pulse(input string tag);
        #2 reset = 1'b0;
        #1;
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_valid"}, bus.ks_valid, 0);
        check({tag, "_byte"}, bus.ks_byte, 0);
        @(negedge clk);
        reset = 1'b1;
        check({tag, "_held_busy"}, bus.busy, 0);
    endtask

    initial begin
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.key      = '0;
        bus.ks_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_valid", bus.ks_valid, 0);
        check("rst_byte", bus.ks_byte, 0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_busy", bus.busy, 0);
        check("idle_valid", bus.ks_valid, 0);

        // "Key" for five bytes, then re-key to "Wiki" while a byte is pending.
        start_key("Key", 0, 80'hEB9F7781B734CA72A719, 10);
        consume(5, 1'b0);
        start_key("Wiki", 0, 80'h6044DB6D41B7, 6);
        consume(6, 1'b0);

        // "Secret" under random backpressure.
        start_key("Secret", 0, 80'h04D46B053CA87B59, 8);
        consume(8, 1'b1);

        // "Key" with an ignored start during KSA, backpressure, then a long run.
        start_key("Key", 1, 80'hEB9F7781B734CA72A719, 10);
        consume(10, 1'b1);
        model_push("Key", 10, 2000);
        consume(2000, 1'b0);

        // Reset mid-GEN, then a clean restart.
        reset_pulse("rst_gen");
        start_key("Wiki", 0, 80'h6044DB6D41B7, 6);
        consume(6, 1'b0);

        // Reset mid-KSA, then a clean restart.
        bus.key   = make_key("Key");
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (399) @(negedge clk);
        check("mid_ksa_busy", bus.busy, 1);
        reset_pulse("rst_ksa");
        start_key("Key", 0, 80'hEB9F7781B734CA72A719, 10);
        consume(10, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
